// File: rtl/axis_lb_pkg.sv
// Shared types, TUSER field positions and helpers for the AXI4-Stream loopback buffer.
package axis_lb_pkg;

  // Per-message handling mode; the reserved encoding 3 decodes to HOLD.
  typedef enum logic [1:0] {
    ModeLoop = 2'd0,
    ModeSink = 2'd1,
    ModeHold = 2'd2
  } mode_e;

  // Slave-side message state.
  typedef enum logic {
    StIdle  = 1'b0,
    StInMsg = 1'b1
  } state_e;

  // TUSER field positions: transfer length in bytes and opcode.
  localparam int unsigned LEN_LSB = 16;
  localparam int unsigned LEN_MSB = 31;
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 7;

  // Widest strobe the popcount helper handles (DATA_W up to 1024).
  localparam int unsigned MaxStrbW = 128;

  // Count of set strobe bits; callers zero-extend their strobe to MaxStrbW.
  function automatic logic [15:0] popcount(input logic [MaxStrbW-1:0] strb);
    logic [15:0] cnt;
    cnt = '0;
    for (int i = 0; i < MaxStrbW; i++) begin
      cnt = cnt + {15'd0, strb[i]};
    end
    return cnt;
  endfunction

  function automatic mode_e decode_mode(input logic [1:0] mode);
    case (mode)
      2'd0:    return ModeLoop;
      2'd1:    return ModeSink;
      default: return ModeHold;
    endcase
  endfunction

endpackage

// File: rtl/axis_fifo_sync.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides and an occupancy output.
// Read data comes straight from the storage flops and is forced to zero while empty.
module axis_fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [WIDTH-1:0]         out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             push, pop;

  // Full blocks pushes even when a pop happens in the same cycle.
  always_comb begin
    in_ready_o  = (count_q != (PtrW + 1)'(DEPTH));
    out_valid_o = (count_q != '0);
    out_data_o  = out_valid_o ? mem_q[rptr_q] : '0;
    push        = in_valid_i & in_ready_o;
    pop         = out_valid_o & out_ready_i;
    level_o     = count_q;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because reads are gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= in_data_i;
  end

endmodule

// File: rtl/axis_loopback_buf.sv
// Buffered AXI4-Stream loopback with per-message loop/sink/hold mode, message counters and a
// sticky check of accepted byte count against the TUSER length field.
module axis_loopback_buf
  import axis_lb_pkg::*;
#(
  parameter int unsigned  DATA_W = 32,
  parameter int unsigned  USER_W = 32,
  parameter int unsigned  DEPTH  = 16,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [1:0]               MODE,
  input  logic [DATA_W-1:0]        S_AXIS_DAT_TDATA,
  input  logic [STRB_W-1:0]        S_AXIS_DAT_TSTRB,
  input  logic [USER_W-1:0]        S_AXIS_DAT_TUSER,
  input  logic                     S_AXIS_DAT_TLAST,
  input  logic                     S_AXIS_DAT_TVALID,
  output logic                     S_AXIS_DAT_TREADY,
  output logic [DATA_W-1:0]        M_AXIS_DAT_TDATA,
  output logic [STRB_W-1:0]        M_AXIS_DAT_TSTRB,
  output logic [USER_W-1:0]        M_AXIS_DAT_TUSER,
  output logic                     M_AXIS_DAT_TLAST,
  output logic                     M_AXIS_DAT_TVALID,
  input  logic                     M_AXIS_DAT_TREADY,
  output logic [15:0]              MSG_CNT,
  output logic [15:0]              DROP_CNT,
  output logic                     LEN_ERR,
  output logic [$clog2(DEPTH):0]   FIFO_LVL
);

  localparam int unsigned FifoW = DATA_W + STRB_W + USER_W + 1;

  state_e      state_q, state_d;
  mode_e       cur_mode_q, cur_mode_d;
  mode_e       eff_mode;
  logic [15:0] len_exp_q, len_exp_d;
  logic [15:0] byte_acc_q, byte_acc_d;
  logic [15:0] msg_cnt_q, msg_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        len_err_q, len_err_d;

  logic             fifo_in_ready;
  logic [FifoW-1:0] fifo_out_data;
  logic             s_ready, beat_acc, push;
  logic [15:0]      beat_bytes, byte_total, len_cmp;

  axis_fifo_sync #(
    .WIDTH (FifoW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (ACLK),
    .rst_i       (ARESET),
    .in_data_i   ({S_AXIS_DAT_TLAST, S_AXIS_DAT_TUSER, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TDATA}),
    .in_valid_i  (push),
    .in_ready_o  (fifo_in_ready),
    .out_data_o  (fifo_out_data),
    .out_valid_o (M_AXIS_DAT_TVALID),
    .out_ready_i (M_AXIS_DAT_TREADY),
    .level_o     (FIFO_LVL)
  );

  // Slave readiness from effective mode; an open message keeps its latched mode.
  always_comb begin
    eff_mode = (state_q == StIdle) ? decode_mode(MODE) : cur_mode_q;
    s_ready  = 1'b0;
    if (!ARESET) begin
      case (eff_mode)
        ModeLoop: s_ready = fifo_in_ready;
        ModeSink: s_ready = 1'b1;
        default:  s_ready = 1'b0;
      endcase
    end
    beat_acc   = S_AXIS_DAT_TVALID & s_ready;
    push       = beat_acc & (eff_mode == ModeLoop);
    beat_bytes = popcount(MaxStrbW'(S_AXIS_DAT_TSTRB));
    byte_total = byte_acc_q + beat_bytes;
    // A one-beat message is checked against its own length field.
    len_cmp    = (state_q == StIdle) ? S_AXIS_DAT_TUSER[LEN_MSB:LEN_LSB] : len_exp_q;
  end

  // Next-state: message FSM, byte accumulator, counters and sticky length error.
  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    len_exp_d  = len_exp_q;
    byte_acc_d = byte_acc_q;
    msg_cnt_d  = msg_cnt_q;
    drop_cnt_d = drop_cnt_q;
    len_err_d  = len_err_q;
    if (beat_acc) begin
      if (S_AXIS_DAT_TLAST) begin
        state_d    = StIdle;
        byte_acc_d = '0;
        msg_cnt_d  = msg_cnt_q + 16'd1;
        if (eff_mode == ModeSink) drop_cnt_d = drop_cnt_q + 16'd1;
        if (byte_total != len_cmp) len_err_d = 1'b1;
      end else begin
        byte_acc_d = byte_total;
        if (state_q == StIdle) begin
          state_d    = StInMsg;
          cur_mode_d = eff_mode;
          len_exp_d  = S_AXIS_DAT_TUSER[LEN_MSB:LEN_LSB];
        end
      end
    end
  end

  // State registers; reset drops any partial message without counting or checking it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= StIdle;
      cur_mode_q <= ModeLoop;
      len_exp_q  <= '0;
      byte_acc_q <= '0;
      msg_cnt_q  <= '0;
      drop_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      len_exp_q  <= len_exp_d;
      byte_acc_q <= byte_acc_d;
      msg_cnt_q  <= msg_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  // Output mapping.
  always_comb begin
    S_AXIS_DAT_TREADY = s_ready;
    {M_AXIS_DAT_TLAST, M_AXIS_DAT_TUSER, M_AXIS_DAT_TSTRB, M_AXIS_DAT_TDATA} = fifo_out_data;
    MSG_CNT  = msg_cnt_q;
    DROP_CNT = drop_cnt_q;
    LEN_ERR  = len_err_q;
  end

endmodule
